// File: rtl/poly_note_pkg.sv
// Shared tables and state encodings for the polyphonic note player.
// SINE is one full period (peak 32767); NOTE_STEP is the per-sample phase increment per note (A1=1, 48 kHz, 22-bit phase).
package poly_note_pkg;

    localparam int SINE_W      = 16;
    localparam int TBL_PHASE_W = 22;

    typedef enum logic {V_IDLE, V_PLAYING} voice_state_e;
    typedef enum logic [1:0] {MIX_IDLE, MIX_ACC, MIX_OUT} mix_state_e;

    localparam logic signed [SINE_W-1:0] SINE [0:63] = '{
        16'sd0,      16'sd3212,   16'sd6393,   16'sd9512,   16'sd12539,  16'sd15446,  16'sd18204,  16'sd20787,
        16'sd23170,  16'sd25329,  16'sd27245,  16'sd28898,  16'sd30273,  16'sd31356,  16'sd32137,  16'sd32609,
        16'sd32767,  16'sd32609,  16'sd32137,  16'sd31356,  16'sd30273,  16'sd28898,  16'sd27245,  16'sd25329,
        16'sd23170,  16'sd20787,  16'sd18204,  16'sd15446,  16'sd12539,  16'sd9512,   16'sd6393,   16'sd3212,
        16'sd0,     -16'sd3212,  -16'sd6393,  -16'sd9512,  -16'sd12539, -16'sd15446, -16'sd18204, -16'sd20787,
       -16'sd23170, -16'sd25329, -16'sd27245, -16'sd28898, -16'sd30273, -16'sd31356, -16'sd32137, -16'sd32609,
       -16'sd32767, -16'sd32609, -16'sd32137, -16'sd31356, -16'sd30273, -16'sd28898, -16'sd27245, -16'sd25329,
       -16'sd23170, -16'sd20787, -16'sd18204, -16'sd15446, -16'sd12539, -16'sd9512,  -16'sd6393,  -16'sd3212
    };

    localparam logic [TBL_PHASE_W-1:0] NOTE_STEP [0:63] = '{
        22'd0,
        22'd4806,   22'd5092,   22'd5395,   22'd5715,   22'd6055,   22'd6415,
        22'd6797,   22'd7201,   22'd7629,   22'd8083,   22'd8563,   22'd9072,
        22'd9612,   22'd10184,  22'd10789,  22'd11431,  22'd12110,  22'd12830,
        22'd13593,  22'd14402,  22'd15258,  22'd16165,  22'd17127,  22'd18145,
        22'd19224,  22'd20367,  22'd21578,  22'd22861,  22'd24221,  22'd25661,
        22'd27187,  22'd28803,  22'd30516,  22'd32331,  22'd34253,  22'd36290,
        22'd38448,  22'd40734,  22'd43156,  22'd45722,  22'd48441,  22'd51322,
        22'd54373,  22'd57607,  22'd61032,  22'd64661,  22'd68506,  22'd72580,
        22'd76896,  22'd81468,  22'd86312,  22'd91445,  22'd96882,  22'd102643,
        22'd108747, 22'd115213, 22'd122064, 22'd129322, 22'd137012, 22'd145159,
        22'd153791, 22'd162936, 22'd172625
    };

endpackage

// File: rtl/poly_voice.sv
// One voice: duration countdown on beats, phase accumulator advanced by the mixer, sine contribution out.
// POLY_NOTE_DECAY_EN adds a 2-bit per-beat attenuation; a load always wins over an expiring beat.
module poly_voice
    import poly_note_pkg::*;
#(
    parameter int NOTE_W  = 6,
    parameter int DUR_W   = 6,
    parameter int PHASE_W = 22
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play_enable_i,
    input  logic                     load_i,
    input  logic [NOTE_W-1:0]        note_i,
    input  logic [DUR_W-1:0]         dur_i,
    input  logic                     beat_i,
    input  logic                     adv_i,
    output logic signed [SINE_W-1:0] contrib_o,
    output logic                     active_o,
    output logic                     done_o
);

    voice_state_e             state_q;
    logic [DUR_W-1:0]         rem_q;
    logic [PHASE_W-1:0]       phase_q;
    logic [PHASE_W-1:0]       step_q;
    logic                     rest_q;
    logic                     done_q;
    logic signed [SINE_W-1:0] sine_w;
`ifdef POLY_NOTE_DECAY_EN
    logic [1:0]               att_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= V_IDLE;
            rem_q   <= '0;
            phase_q <= '0;
            step_q  <= '0;
            rest_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef POLY_NOTE_DECAY_EN
            att_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (load_i) begin
                state_q <= V_PLAYING;
                rem_q   <= dur_i;
                phase_q <= '0;
                step_q  <= PHASE_W'(NOTE_STEP[note_i]);
                rest_q  <= (note_i == '0);
`ifdef POLY_NOTE_DECAY_EN
                att_q   <= '0;
`endif
            end else begin
                if (adv_i && state_q == V_PLAYING && !rest_q)
                    phase_q <= phase_q + step_q;
                if (beat_i && play_enable_i && state_q == V_PLAYING) begin
                    // a loaded duration of 0 behaves like 1: expires on the first beat
                    if (rem_q < DUR_W'(2)) begin
                        state_q <= V_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        rem_q <= rem_q - DUR_W'(1);
                    end
`ifdef POLY_NOTE_DECAY_EN
                    if (att_q != 2'd3)
                        att_q <= att_q + 2'd1;
`endif
                end
            end
        end
    end

    always_comb begin
        sine_w    = SINE[phase_q[PHASE_W-1 -: 6]];
        contrib_o = '0;
        if (state_q == V_PLAYING && !rest_q) begin
`ifdef POLY_NOTE_DECAY_EN
            contrib_o = sine_w >>> att_q;
`else
            contrib_o = sine_w;
`endif
        end
    end

    assign active_o = (state_q == V_PLAYING);
    assign done_o   = done_q;

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic player: VOICES poly_voice instances mixed one voice per clock into a saturated sample.
// sample_ready follows sampling_pulse by VOICES+1 clocks; pulses during a mix are dropped and set sticky overrun.
module poly_note_player
    import poly_note_pkg::*;
#(
    parameter int VOICES   = 3,
    parameter int NOTE_W   = 6,
    parameter int DUR_W    = 6,
    parameter int SAMPLE_W = 16,
    parameter int PHASE_W  = 22,
    localparam int SEL_W   = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play_enable,
    input  logic                load_new_note,
    input  logic [SEL_W-1:0]    voice_sel,
    input  logic [NOTE_W-1:0]   note_to_load,
    input  logic [DUR_W-1:0]    duration_to_load,
    input  logic                beat,
    input  logic                sampling_pulse,
    output logic [VOICES-1:0]   note_done,
    output logic [VOICES-1:0]   voice_active,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_ready,
    output logic                overrun
);

    localparam int NSLOT = 1 << SEL_W;
    localparam int ACC_W = SAMPLE_W + $clog2(VOICES) + 1;
    localparam logic [SAMPLE_W-1:0]     SAT_HI = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0]     SAT_LO = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_HI = {{(ACC_W-SAMPLE_W){1'b0}}, SAT_HI};
    localparam logic signed [ACC_W-1:0] ACC_LO = {{(ACC_W-SAMPLE_W){1'b1}}, SAT_LO};

    mix_state_e               mix_q;
    logic [SEL_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [SAMPLE_W-1:0]      sat_d;
    logic [SAMPLE_W-1:0]      sample_q;
    logic                     ready_q;
    logic                     overrun_q;
    logic signed [SINE_W-1:0] contrib [NSLOT];

    // Slots beyond VOICES read as silence so the mixer can index with a full-width idx_q.
    for (genvar v = 0; v < NSLOT; v++) begin : g_voice
        if (v < VOICES) begin : g_on
            logic load_v;
            logic adv_v;
            assign load_v = load_new_note && (voice_sel == SEL_W'(v));
            assign adv_v  = (mix_q == MIX_ACC) && (idx_q == SEL_W'(v));
            poly_voice #(
                .NOTE_W  (NOTE_W),
                .DUR_W   (DUR_W),
                .PHASE_W (PHASE_W)
            ) u_voice (
                .clk           (clk),
                .reset         (reset),
                .play_enable_i (play_enable),
                .load_i        (load_v),
                .note_i        (note_to_load),
                .dur_i         (duration_to_load),
                .beat_i        (beat),
                .adv_i         (adv_v),
                .contrib_o     (contrib[v]),
                .active_o      (voice_active[v]),
                .done_o        (note_done[v])
            );
        end else begin : g_off
            assign contrib[v] = '0;
        end
    end

    always_comb begin
        acc_d = acc_q + ACC_W'(contrib[idx_q]);
        sat_d = acc_q[SAMPLE_W-1:0];
        if (acc_q > ACC_HI)
            sat_d = SAT_HI;
        else if (acc_q < ACC_LO)
            sat_d = SAT_LO;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mix_q     <= MIX_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            sample_q  <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (mix_q)
                MIX_IDLE: begin
                    if (sampling_pulse && play_enable) begin
                        mix_q <= MIX_ACC;
                        idx_q <= '0;
                        acc_q <= '0;
                    end
                end
                MIX_ACC: begin
                    acc_q <= acc_d;
                    if (idx_q == SEL_W'(VOICES - 1))
                        mix_q <= MIX_OUT;
                    else
                        idx_q <= idx_q + SEL_W'(1);
                end
                MIX_OUT: begin
                    sample_q <= sat_d;
                    ready_q  <= 1'b1;
                    mix_q    <= MIX_IDLE;
                end
                default: mix_q <= MIX_IDLE;
            endcase
            if (sampling_pulse && play_enable && mix_q != MIX_IDLE)
                overrun_q <= 1'b1;
        end
    end

    assign sample       = sample_q;
    assign sample_ready = ready_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_poly_note_player.sv
// Scoreboarded bench for poly_note_player (VOICES=3, default build).
// Stimulus pushes expected samples and their arrival cycle; a negedge monitor pops on sample_ready.
module tb_poly_note_player;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        play_enable = 1'b0;
    logic        load_new_note = 1'b0;
    logic [1:0]  voice_sel = '0;
    logic [5:0]  note_to_load = '0;
    logic [5:0]  duration_to_load = '0;
    logic        beat = 1'b0;
    logic        sampling_pulse = 1'b0;
    logic [2:0]  note_done;
    logic [2:0]  voice_active;
    logic [15:0] sample;
    logic        sample_ready;
    logic        overrun;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] s;
        int          c;
    } exp_t;
    exp_t exp_q[$];

    // three voices on note 61 (step 153791): mix k reads SINE[(k*153791)>>16] times 3, clamped
    int sat_tab [17] = '{0, 19179, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                         32767, 32767, 32767, 32767, 19179, 0, -28536, -32768};

    poly_note_player dut (
        .clk              (clk),
        .reset            (reset),
        .play_enable      (play_enable),
        .load_new_note    (load_new_note),
        .voice_sel        (voice_sel),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .beat             (beat),
        .sampling_pulse   (sampling_pulse),
        .note_done        (note_done),
        .voice_active     (voice_active),
        .sample           (sample),
        .sample_ready     (sample_ready),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sample_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ready: sample_ready=1 at cycle %0d, required 0", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_vec++;
                if (sample !== e.s) begin
                    n_bad++;
                    $display("FAIL sample: got %0d required %0d", $signed(sample), $signed(e.s));
                end
                n_vec++;
                if (cyc != e.c) begin
                    n_bad++;
                    $display("FAIL latency: ready at cycle %0d required %0d", cyc, e.c);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic load(input int v, input int n, input int d);
        voice_sel        = 2'(v);
        note_to_load     = 6'(n);
        duration_to_load = 6'(d);
        load_new_note    = 1'b1;
        tick(1);
        load_new_note    = 1'b0;
    endtask

    task automatic do_beat();
        beat = 1'b1;
        tick(1);
        beat = 1'b0;
    endtask

    task automatic mix(input logic [15:0] e);
        exp_t x;
        x.s = e;
        x.c = cyc + 5;
        exp_q.push_back(x);
        sampling_pulse = 1'b1;
        tick(1);
        sampling_pulse = 1'b0;
        tick(5);
    endtask

    initial begin
        tick(3);
        chk("rst_note_done", note_done, 3'b000);
        chk("rst_active", voice_active, 3'b000);
        chk("rst_sample", sample, 16'h0000);
        chk("rst_ready", sample_ready, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        reset = 1'b1;
        play_enable = 1'b1;
        tick(2);

        // silent mix, with a second pulse two clocks in
        begin
            exp_t x;
            x.s = 16'h0000;
            x.c = cyc + 5;
            exp_q.push_back(x);
        end
        sampling_pulse = 1'b1;
        tick(1);
        sampling_pulse = 1'b0;
        tick(1);
        chk("overrun_before", overrun, 1'b0);
        sampling_pulse = 1'b1;
        tick(1);
        sampling_pulse = 1'b0;
        chk("overrun_set", overrun, 1'b1);
        tick(4);

        // duration expiry
        load(0, 38, 3);
        chk("load_active", voice_active, 3'b001);
        for (int b = 1; b <= 3; b++) begin
            tick(63);
            do_beat();
            if (b < 3) begin
                chk("beat_no_done", note_done, 3'b000);
                chk("beat_active", voice_active, 3'b001);
            end else begin
                chk("expire_done", note_done, 3'b001);
                chk("expire_idle", voice_active, 3'b000);
            end
        end
        tick(1);
        chk("done_one_clk", note_done, 3'b000);

        // single voice waveform
        load(0, 61, 60);
        mix(16'd0);
        mix(16'd6393);
        mix(16'd12539);
        mix(16'd20787);

        // three voices in phase: saturation both ways
        load(0, 61, 60);
        load(1, 61, 60);
        load(2, 61, 60);
        for (int k = 0; k < 17; k++)
            mix(16'(sat_tab[k]));

        // reload on the expiring beat
        load(1, 0, 2);
        do_beat();
        chk("v1_countdown", note_done, 3'b000);
        beat             = 1'b1;
        voice_sel        = 2'd1;
        note_to_load     = 6'd0;
        duration_to_load = 6'd5;
        load_new_note    = 1'b1;
        tick(1);
        beat          = 1'b0;
        load_new_note = 1'b0;
        chk("reload_no_done", note_done, 3'b000);
        chk("reload_active", voice_active, 3'b111);
        for (int i = 1; i <= 5; i++) begin
            tick(3);
            do_beat();
            if (i < 5)
                chk("reload_wait", note_done, 3'b000);
            else begin
                chk("reload_expire", note_done, 3'b010);
                chk("reload_idle", voice_active, 3'b101);
            end
        end

        // freeze
        load(2, 0, 2);
        play_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(4);
            sampling_pulse = 1'b1;
            beat           = 1'b1;
            tick(1);
            sampling_pulse = 1'b0;
            beat           = 1'b0;
            tick(5);
        end
        chk("freeze_sample", sample, 16'h8000);
        chk("freeze_overrun", overrun, 1'b1);
        chk("freeze_active", voice_active, 3'b101);
        chk("freeze_done", note_done, 3'b000);
        play_enable = 1'b1;
        mix(-16'sd20787);
        mix(-16'sd27245);
        do_beat();
        chk("thaw_beat1", note_done, 3'b000);
        do_beat();
        chk("thaw_beat2", note_done, 3'b100);
        chk("thaw_active", voice_active, 3'b001);

        // reset in the middle of a mix
        sampling_pulse = 1'b1;
        tick(1);
        sampling_pulse = 1'b0;
        tick(1);
        reset = 1'b0;
        #2;
        chk("midrst_note_done", note_done, 3'b000);
        chk("midrst_active", voice_active, 3'b000);
        chk("midrst_sample", sample, 16'h0000);
        chk("midrst_ready", sample_ready, 1'b0);
        chk("midrst_overrun", overrun, 1'b0);
        tick(3);
        reset = 1'b1;
        tick(10);

        load(3, 38, 5);
        chk("sel_out_of_range", voice_active, 3'b000);

        tick(5);
        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
